wb_rr_arbiter_2: RTL
====================

WB_RR_ARBITER_2 -- requirements
Module: wb_rr_arbiter_2

Interface
REQ-001 Parameter ADDR_WIDTH, default 32: address width in bits.
REQ-002 Parameter DATA_WIDTH, default 32: data width in bits (8, 16, 32 or 64).
REQ-003 Parameter SELECT_WIDTH, default DATA_WIDTH/8: select width in bits.
REQ-004 Parameter TIMEOUT, default 255: slave-response watchdog limit in cycles, range 1..65535.
REQ-005 clk  in  1  clock; all state SHALL update on its rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 wbmN_adr_i/dat_i/we_i/sel_i/stb_i/cyc_i  in  ADDR_WIDTH/DATA_WIDTH/1/SELECT_WIDTH/1/1  master N request, N = 0 and 1.
REQ-008 wbmN_dat_o/ack_o/err_o/rty_o  out  DATA_WIDTH/1/1/1  master N response, N = 0 and 1.
REQ-009 wbs_adr_o/dat_o/we_o/sel_o/stb_o/cyc_o  out  ADDR_WIDTH/DATA_WIDTH/1/SELECT_WIDTH/1/1  shared slave request.
REQ-010 wbs_dat_i/ack_i/err_i/rty_i  in  DATA_WIDTH/1/1/1  shared slave response.

Function
REQ-011 The arbiter SHALL hold registered state IDLE, GRANT0 or GRANT1, plus a 1-bit last_grant register.
REQ-012 In IDLE, exactly one requester (wbmN_cyc_i=1) SHALL move the arbiter to GRANTN at the next edge.
REQ-013 In IDLE with both cyc_i high, the arbiter SHALL grant the master not equal to last_grant.
REQ-014 On entry to GRANTN, last_grant SHALL be set to N.
REQ-015 In GRANTN, all wbs_* request outputs SHALL be a combinational pass-through of master N's inputs; wbs_cyc_o SHALL equal wbmN_cyc_i.
REQ-016 In GRANTN, master N's ack/err/rty SHALL be a combinational pass-through of the slave's.
REQ-017 The non-granted master's ack_o/err_o/rty_o SHALL be 0.
REQ-018 wbm0_dat_o and wbm1_dat_o SHALL both equal wbs_dat_i at all times.
REQ-019 In IDLE, wbs_cyc_o, wbs_stb_o and wbs_we_o SHALL be 0; wbs_adr_o, wbs_dat_o and wbs_sel_o SHALL be 0.
REQ-020 GRANTN SHALL be held while wbmN_cyc_i=1, regardless of the other master.
REQ-021 GRANTN SHALL return to IDLE at the first edge with wbmN_cyc_i=0, giving one dead cycle before any new grant.
REQ-022 Latency: cyc_i rising in cycle n SHALL produce wbs_cyc_o=1 in cycle n+1 at the earliest.
REQ-023 A master dropping cyc_i mid-transfer SHALL end the slave cycle in the same cycle (wbs_cyc_o=0); no response SHALL be forwarded afterwards.

Reset
REQ-024 While rst=1 at an edge: state SHALL become IDLE and last_grant SHALL become 1, so master 0 wins the first tie.
REQ-025 After reset, all outputs SHALL take their IDLE values (REQ-017, REQ-019); when both masters request, a grant SHALL occur no earlier than the cycle after rst falls.
REQ-026 Reset asserted during GRANTN SHALL abort the transfer; wbs_cyc_o SHALL be 0 in the cycle following the reset edge.

Configuration
REQ-027 Macro WB_RR_ARBITER_TIMEOUT_EN, when defined, SHALL compile in a 16-bit watchdog counter.
REQ-028 With the macro defined, the counter SHALL be cleared in IDLE, on reset, and whenever wbs_stb_o=0 or any of ack_i/err_i/rty_i is 1; otherwise it SHALL increment.
REQ-029 With the macro defined, when the counter equals TIMEOUT the granted master's err_o SHALL be 1 and wbs_stb_o SHALL be 0 for that single cycle, and the counter SHALL clear.
REQ-030 Without the macro, no counter SHALL exist, err_o SHALL be pure pass-through, and a hung slave SHALL hold the grant indefinitely.

Verification
REQ-031 Reset, then both cyc/stb high in the same cycle -> GRANT0 first; after master 0 drops cyc and one dead cycle, GRANT1.
REQ-032 Master 0 write, adr=0x10, dat=0xDEADBEEF, sel=0xF; slave acks after 3 cycles -> wbs_* mirror the request; wbm0_ack_o pulses once; wbm1_ack_o stays 0.
REQ-033 Master 1 holds cyc over 4 back-to-back reads while master 0 requests -> master 1 keeps the grant for all 4; master 0 is granted afterwards.
REQ-034 Granted master drops cyc before ack; slave acks next cycle -> wbs_cyc_o=0 immediately; ack is not forwarded.
REQ-035 With WB_RR_ARBITER_TIMEOUT_EN and TIMEOUT=8, slave never responds -> err_o=1 exactly on the 9th stb cycle, wbs_stb_o=0 that cycle.
REQ-036 rst asserted mid-grant -> wbs_cyc_o=0 on the next cycle; master 0 wins the next tie.

Source files
------------

// File: rtl/wb_rr_arbiter_2_if.sv
// Bus bundle for the two-master Wishbone round-robin arbiter.
// The arbiter connects through the slave modport; the environment uses the master modport.
interface wb_rr_arbiter_2_if #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int SELECT_WIDTH = DATA_WIDTH / 8
);
    logic [ADDR_WIDTH-1:0]   wbm0_adr_i;
    logic [DATA_WIDTH-1:0]   wbm0_dat_i;
    logic                    wbm0_we_i;
    logic [SELECT_WIDTH-1:0] wbm0_sel_i;
    logic                    wbm0_stb_i;
    logic                    wbm0_cyc_i;
    logic [DATA_WIDTH-1:0]   wbm0_dat_o;
    logic                    wbm0_ack_o;
    logic                    wbm0_err_o;
    logic                    wbm0_rty_o;

    logic [ADDR_WIDTH-1:0]   wbm1_adr_i;
    logic [DATA_WIDTH-1:0]   wbm1_dat_i;
    logic                    wbm1_we_i;
    logic [SELECT_WIDTH-1:0] wbm1_sel_i;
    logic                    wbm1_stb_i;
    logic                    wbm1_cyc_i;
    logic [DATA_WIDTH-1:0]   wbm1_dat_o;
    logic                    wbm1_ack_o;
    logic                    wbm1_err_o;
    logic                    wbm1_rty_o;

    logic [ADDR_WIDTH-1:0]   wbs_adr_o;
    logic [DATA_WIDTH-1:0]   wbs_dat_o;
    logic                    wbs_we_o;
    logic [SELECT_WIDTH-1:0] wbs_sel_o;
    logic                    wbs_stb_o;
    logic                    wbs_cyc_o;
    logic [DATA_WIDTH-1:0]   wbs_dat_i;
    logic                    wbs_ack_i;
    logic                    wbs_err_i;
    logic                    wbs_rty_i;

    modport slave (
        input  wbm0_adr_i, wbm0_dat_i, wbm0_we_i, wbm0_sel_i, wbm0_stb_i, wbm0_cyc_i,
        output wbm0_dat_o, wbm0_ack_o, wbm0_err_o, wbm0_rty_o,
        input  wbm1_adr_i, wbm1_dat_i, wbm1_we_i, wbm1_sel_i, wbm1_stb_i, wbm1_cyc_i,
        output wbm1_dat_o, wbm1_ack_o, wbm1_err_o, wbm1_rty_o,
        output wbs_adr_o, wbs_dat_o, wbs_we_o, wbs_sel_o, wbs_stb_o, wbs_cyc_o,
        input  wbs_dat_i, wbs_ack_i, wbs_err_i, wbs_rty_i
    );

    modport master (
        output wbm0_adr_i, wbm0_dat_i, wbm0_we_i, wbm0_sel_i, wbm0_stb_i, wbm0_cyc_i,
        input  wbm0_dat_o, wbm0_ack_o, wbm0_err_o, wbm0_rty_o,
        output wbm1_adr_i, wbm1_dat_i, wbm1_we_i, wbm1_sel_i, wbm1_stb_i, wbm1_cyc_i,
        input  wbm1_dat_o, wbm1_ack_o, wbm1_err_o, wbm1_rty_o,
        input  wbs_adr_o, wbs_dat_o, wbs_we_o, wbs_sel_o, wbs_stb_o, wbs_cyc_o,
        output wbs_dat_i, wbs_ack_i, wbs_err_i, wbs_rty_i
    );
endinterface

// File: rtl/wb_rr_arbiter_2.sv
// Two-master Wishbone round-robin arbiter sharing one slave; grant is held for the whole cycle.
// Define WB_RR_ARBITER_TIMEOUT_EN to add a slave-response watchdog that errors after TIMEOUT cycles.
module wb_rr_arbiter_2 #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int SELECT_WIDTH = DATA_WIDTH / 8,
    parameter int TIMEOUT      = 255
) (
    input logic             clk,
    input logic             rst,
    wb_rr_arbiter_2_if.slave bus
);
    typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_e;

    if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_timeout_range
        $error("TIMEOUT out of range 1..65535");
    end

    state_e state_q, state_d;
    logic   last_grant_q, last_grant_d;
    logic   timeout_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        unique case (state_q)
            IDLE: begin
                if (bus.wbm0_cyc_i && bus.wbm1_cyc_i) begin
                    state_d      = last_grant_q ? GRANT0 : GRANT1;
                    last_grant_d = ~last_grant_q;
                end else if (bus.wbm0_cyc_i) begin
                    state_d      = GRANT0;
                    last_grant_d = 1'b0;
                end else if (bus.wbm1_cyc_i) begin
                    state_d      = GRANT1;
                    last_grant_d = 1'b1;
                end
            end
            GRANT0: if (!bus.wbm0_cyc_i) state_d = IDLE;
            GRANT1: if (!bus.wbm1_cyc_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign bus.wbm0_dat_o = bus.wbs_dat_i;
    assign bus.wbm1_dat_o = bus.wbs_dat_i;

    always_comb begin
        bus.wbs_adr_o  = '0;
        bus.wbs_dat_o  = '0;
        bus.wbs_we_o   = 1'b0;
        bus.wbs_sel_o  = '0;
        bus.wbs_stb_o  = 1'b0;
        bus.wbs_cyc_o  = 1'b0;
        bus.wbm0_ack_o = 1'b0;
        bus.wbm0_err_o = 1'b0;
        bus.wbm0_rty_o = 1'b0;
        bus.wbm1_ack_o = 1'b0;
        bus.wbm1_err_o = 1'b0;
        bus.wbm1_rty_o = 1'b0;
        unique case (state_q)
            GRANT0: begin
                bus.wbs_adr_o  = bus.wbm0_adr_i;
                bus.wbs_dat_o  = bus.wbm0_dat_i;
                bus.wbs_we_o   = bus.wbm0_we_i;
                bus.wbs_sel_o  = bus.wbm0_sel_i;
                bus.wbs_stb_o  = bus.wbm0_stb_i & ~timeout_hit;
                bus.wbs_cyc_o  = bus.wbm0_cyc_i;
                bus.wbm0_ack_o = bus.wbs_ack_i;
                bus.wbm0_err_o = bus.wbs_err_i | timeout_hit;
                bus.wbm0_rty_o = bus.wbs_rty_i;
            end
            GRANT1: begin
                bus.wbs_adr_o  = bus.wbm1_adr_i;
                bus.wbs_dat_o  = bus.wbm1_dat_i;
                bus.wbs_we_o   = bus.wbm1_we_i;
                bus.wbs_sel_o  = bus.wbm1_sel_i;
                bus.wbs_stb_o  = bus.wbm1_stb_i & ~timeout_hit;
                bus.wbs_cyc_o  = bus.wbm1_cyc_i;
                bus.wbm1_ack_o = bus.wbs_ack_i;
                bus.wbm1_err_o = bus.wbs_err_i | timeout_hit;
                bus.wbm1_rty_o = bus.wbs_rty_i;
            end
            default: ;
        endcase
    end

`ifdef WB_RR_ARBITER_TIMEOUT_EN
    logic [15:0] wd_q, wd_d;

    // The forced stb drop on a hit also clears the counter through the stb term.
    assign timeout_hit = (state_q != IDLE) && (wd_q == 16'(TIMEOUT));

    always_comb begin
        wd_d = wd_q + 16'd1;
        if (state_q == IDLE || !bus.wbs_stb_o ||
            bus.wbs_ack_i || bus.wbs_err_i || bus.wbs_rty_i) begin
            wd_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) wd_q <= '0;
        else     wd_q <= wd_d;
    end
`else
    assign timeout_hit = 1'b0;
`endif
endmodule
